// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and typedefs for the register file with busy scoreboard.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_IDX_W    = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_IDX_W-1:0]  reg_idx_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bus of the register file: read ports, writeback, alloc, busy count.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic              rd_en;
    logic [IDX_W-1:0]  rs1_idx;
    logic [IDX_W-1:0]  rs2_idx;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              alloc_en;
    logic [IDX_W-1:0]  alloc_idx;
    logic [IDX_W:0]    busy_count;

    modport master (
        output rd_en, rs1_idx, rs2_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
    );

    modport slave (
        input  rd_en, rs1_idx, rs2_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_count
    );

endinterface

// File: rtl/regfile_scoreboard_busy_scoreboard.sv
// Per-register busy vector: alloc sets, retire clears, alloc wins on a collision.
// Exposes the post-update busy bit for two indices and a registered popcount.
module busy_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_en_i,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  logic             retire_en_i,
    input  logic [IDX_W-1:0] retire_idx_i,
    input  logic [IDX_W-1:0] lookup1_idx_i,
    input  logic [IDX_W-1:0] lookup2_idx_i,
    output logic             lookup1_busy_o,
    output logic             lookup2_busy_o,
    output logic [IDX_W:0]   busy_count_o
);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    // Next busy vector: retire first so a same-cycle alloc of that index supersedes it.
    always_comb begin
        busy_d = busy_q;
        if (retire_en_i) begin
            busy_d[retire_idx_i] = 1'b0;
        end
        if (alloc_en_i) begin
            busy_d[alloc_idx_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Population count of the post-update busy vector.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d = count_d + CNT_W'(busy_d[i]);
        end
    end

    // Busy vector and count registers; reset discards every outstanding alloc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign lookup1_busy_o = busy_d[lookup1_idx_i];
    assign lookup2_busy_o = busy_d[lookup2_idx_i];
    assign busy_count_o   = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write register file with write-to-read bypass and a busy scoreboard.
// Reads are registered; a read sees the state as it is after this cycle's write/alloc.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_scoreboard_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              wr_ok;
    logic              rs1_zero;
    logic              rs2_zero;
    logic [DATA_W-1:0] rs1_data_d;
    logic [DATA_W-1:0] rs2_data_d;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic              rs1_busy_d;
    logic              rs2_busy_d;
    logic              rs1_busy_q;
    logic              rs2_busy_q;
    logic [IDX_W:0]    busy_count;

    assign wr_ok    = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_idx == '0));
    assign rs1_zero = (ZERO_REG != 0) && (bus.rs1_idx == '0);
    assign rs2_zero = (ZERO_REG != 0) && (bus.rs2_idx == '0);

    busy_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .IDX_W    (IDX_W)
    ) u_busy (
        .clk            (clk),
        .reset          (reset),
        .alloc_en_i     (bus.alloc_en),
        .alloc_idx_i    (bus.alloc_idx),
        .retire_en_i    (wr_ok),
        .retire_idx_i   (bus.wr_idx),
        .lookup1_idx_i  (bus.rs1_idx),
        .lookup2_idx_i  (bus.rs2_idx),
        .lookup1_busy_o (rs1_busy_d),
        .lookup2_busy_o (rs2_busy_d),
        .busy_count_o   (busy_count)
    );

    // Register array; writes to the hardwired zero register are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.wr_idx] <= bus.wr_data;
        end
    end

    // Read data select with same-cycle writeback bypass; register 0 always reads zero.
    always_comb begin
        rs1_data_d = regs_q[bus.rs1_idx];
        rs2_data_d = regs_q[bus.rs2_idx];
        if (wr_ok && (bus.wr_idx == bus.rs1_idx)) begin
            rs1_data_d = bus.wr_data;
        end
        if (wr_ok && (bus.wr_idx == bus.rs2_idx)) begin
            rs2_data_d = bus.wr_data;
        end
        if (rs1_zero) begin
            rs1_data_d = '0;
        end
        if (rs2_zero) begin
            rs2_data_d = '0;
        end
    end

    // Read result registers: capture on rd_en, otherwise hold the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_busy_q <= 1'b0;
            rs2_busy_q <= 1'b0;
        end else if (bus.rd_en) begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_busy_q <= rs1_busy_d;
            rs2_busy_q <= rs2_busy_d;
        end
    end

    assign bus.rs1_data   = rs1_data_q;
    assign bus.rs2_data   = rs2_data_q;
    assign bus.rs1_busy   = rs1_busy_q;
    assign bus.rs2_busy   = rs2_busy_q;
    assign bus.busy_count = busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random traffic
// checked every negedge against an array/queue-level model of the register file.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    logic [DW-1:0] modelRegs [NR];
    bit            modelBusy [NR];

    logic [DW-1:0] expRs1Data, expRs2Data;
    logic          expRs1Busy, expRs2Busy;
    logic [IW:0]   expCount;

    regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the model on each negedge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rs1_data",   64'(bus.rs1_data),   64'(expRs1Data));
            checkOutput("rs2_data",   64'(bus.rs2_data),   64'(expRs2Data));
            checkOutput("rs1_busy",   64'(bus.rs1_busy),   64'(expRs1Busy));
            checkOutput("rs2_busy",   64'(bus.rs2_busy),   64'(expRs2Busy));
            checkOutput("busy_count", 64'(bus.busy_count), 64'(expCount));
        end
    end

    task automatic clearModel();
        for (int i = 0; i < NR; i++) begin
            modelRegs[i] = '0;
            modelBusy[i] = 1'b0;
        end
        expRs1Data = '0;
        expRs2Data = '0;
        expRs1Busy = 1'b0;
        expRs2Busy = 1'b0;
        expCount   = '0;
    endtask

    task automatic idleInputs();
        bus.rd_en     = 1'b0;
        bus.rs1_idx   = '0;
        bus.rs2_idx   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_data   = '0;
        bus.alloc_en  = 1'b0;
        bus.alloc_idx = '0;
    endtask

    // Drive one cycle of inputs, advance the model, and expose the post-edge expectations.
    task automatic applyStimulus(input logic rd, input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                                 input logic we, input logic [IW-1:0] wi, input logic [DW-1:0] wd,
                                 input logic ae, input logic [IW-1:0] ai);
        logic [DW-1:0] n1Data, n2Data;
        logic          n1Busy, n2Busy;
        int            cnt;
        bus.rd_en     = rd;
        bus.rs1_idx   = i1;
        bus.rs2_idx   = i2;
        bus.wr_en     = we;
        bus.wr_idx    = wi;
        bus.wr_data   = wd;
        bus.alloc_en  = ae;
        bus.alloc_idx = ai;
        // State after this edge: write/retire, then alloc (new producer wins).
        if (we && wi != 0) begin
            modelRegs[wi] = wd;
            modelBusy[wi] = 1'b0;
        end
        if (ae && ai != 0) begin
            modelBusy[ai] = 1'b1;
        end
        cnt = 0;
        for (int i = 0; i < NR; i++) cnt += int'(modelBusy[i]);
        // A read observes the post-update state, which covers the bypass case.
        n1Data = expRs1Data;
        n2Data = expRs2Data;
        n1Busy = expRs1Busy;
        n2Busy = expRs2Busy;
        if (rd) begin
            n1Data = modelRegs[i1];
            n2Data = modelRegs[i2];
            n1Busy = modelBusy[i1];
            n2Busy = modelBusy[i2];
        end
        @(posedge clk);
        expRs1Data = n1Data;
        expRs2Data = n2Data;
        expRs1Busy = n1Busy;
        expRs2Busy = n2Busy;
        expCount   = (IW+1)'(cnt);
        #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        clearModel();
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    // Main stimulus sequence.
    initial begin
        reset = 1'b1;
        idleInputs();
        clearModel();
        checkEn = 1'b1;

        // Reset then read index 5 and 0.
        doReset(3);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        checkOutput("tp1_rs1_data", 64'(bus.rs1_data), 64'h0);
        checkOutput("tp1_rs2_data", 64'(bus.rs2_data), 64'h0);
        checkOutput("tp1_busy_count", 64'(bus.busy_count), 64'h0);

        // Write then read.
        applyStimulus(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
        applyStimulus(1, 7, 5, 0, 0, 0, 0, 0);
        checkOutput("tp2_rs1_data", 64'(bus.rs1_data), 64'hDEADBEEF);

        // Same-cycle bypass on both ports.
        applyStimulus(0, 0, 0, 1, 3, 32'h11, 0, 0);
        applyStimulus(1, 3, 3, 1, 3, 32'h22, 0, 0);
        checkOutput("tp3_rs1_data", 64'(bus.rs1_data), 64'h22);
        checkOutput("tp3_rs2_data", 64'(bus.rs2_data), 64'h22);
        checkOutput("tp3_rs1_busy", 64'(bus.rs1_busy), 64'h0);

        // Scoreboard alloc / collide / retire on register 9.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        applyStimulus(1, 9, 9, 0, 0, 0, 0, 0);
        checkOutput("tp4a_rs1_busy", 64'(bus.rs1_busy), 64'h1);
        checkOutput("tp4a_busy_count", 64'(bus.busy_count), 64'h1);
        applyStimulus(1, 9, 9, 1, 9, 32'h99, 1, 9);
        checkOutput("tp4b_rs1_busy", 64'(bus.rs1_busy), 64'h1);
        checkOutput("tp4b_rs1_data", 64'(bus.rs1_data), 64'h99);
        applyStimulus(1, 9, 9, 1, 9, 32'h9A, 0, 0);
        checkOutput("tp4c_rs2_busy", 64'(bus.rs2_busy), 64'h0);
        checkOutput("tp4c_busy_count", 64'(bus.busy_count), 64'h0);

        // Register 0 ignores writes and allocs.
        applyStimulus(1, 0, 0, 1, 0, 32'hFFFF, 1, 0);
        checkOutput("tp5_rs1_data", 64'(bus.rs1_data), 64'h0);
        checkOutput("tp5_rs1_busy", 64'(bus.rs1_busy), 64'h0);
        checkOutput("tp5_busy_count", 64'(bus.busy_count), 64'h0);

        // Async reset mid-operation.
        for (int r = 1; r <= 4; r++) applyStimulus(0, 0, 0, 0, 0, 0, 1, IW'(r));
        applyStimulus(0, 0, 0, 1, 2, 32'hA5, 0, 0);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 0);
        checkOutput("tp6_pre_rs1_data", 64'(bus.rs1_data), 64'hA5);
        checkOutput("tp6_pre_rs2_busy", 64'(bus.rs2_busy), 64'h1);
        checkOutput("tp6_pre_busy_count", 64'(bus.busy_count), 64'h3);
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("tp6_rst_rs1_data", 64'(bus.rs1_data), 64'h0);
        checkOutput("tp6_rst_rs2_busy", 64'(bus.rs2_busy), 64'h0);
        checkOutput("tp6_rst_busy_count", 64'(bus.busy_count), 64'h0);
        #1;
        reset = 1'b0;
        applyStimulus(1, 2, 3, 0, 0, 0, 0, 0);
        checkOutput("tp6_post_rs1_data", 64'(bus.rs1_data), 64'h0);
        checkOutput("tp6_post_rs2_busy", 64'(bus.rs2_busy), 64'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [IW-1:0] a, b;
            a = IW'($urandom_range(0, NR-1));
            b = ($urandom_range(0, 3) == 0) ? a : IW'($urandom_range(0, NR-1));
            applyStimulus(($urandom_range(0, 3) != 0),
                          a, b,
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 2) == 0) ? a : IW'($urandom_range(0, NR-1)),
                          $urandom,
                          ($urandom_range(0, 4) < 2),
                          IW'($urandom_range(0, NR-1)));
        end

        idleInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-port processor register file.
- Two synchronous read ports, one write port, and a per-register busy scoreboard with alloc/retire semantics for hazard detection.
- Includes write-to-read bypass.
- Sits between decode (reads, alloc) and writeback (write, retire) in the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, >= 2).
- IDX_W, $clog2(NUM_REGS), register index width (derived, not overridden).
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- rd_en  in  1  capture read results this cycle.
- rs1_idx  in  IDX_W  read port 1 index.
- rs2_idx  in  IDX_W  read port 2 index.
- rs1_data  out  DATA_W  read port 1 data, registered.
- rs2_data  out  DATA_W  read port 2 data, registered.
- rs1_busy  out  1  busy flag of rs1_idx, registered with rs1_data.
- rs2_busy  out  1  busy flag of rs2_idx, registered with rs2_data.
- wr_en  in  1  writeback valid.
- wr_idx  in  IDX_W  writeback index.
- wr_data  in  DATA_W  writeback data.
- alloc_en  in  1  issue marks a destination register busy.
- alloc_idx  in  IDX_W  destination index being allocated.
- busy_count  out  IDX_W+1  number of registers currently busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset state: all registers = 0, all busy bits = 0, rs1_data/rs2_data = 0, rs1_busy/rs2_busy = 0, busy_count = 0. Asserting reset mid-operation discards all pending allocs.
- Write: on posedge with wr_en, registers[wr_idx] <= wr_data and busy[wr_idx] is cleared (retire).
- Write to register 0 with ZERO_REG=1: data is dropped and the busy bit is unaffected.
- Alloc: on posedge with alloc_en, busy[alloc_idx] <= 1. alloc_idx = 0 is ignored when ZERO_REG=1.
- Simultaneous alloc and write to the same idx: alloc wins and busy stays 1 (a new producer supersedes the retiring one). Data is still written.
- Alloc of an already-busy register: busy stays 1; no error.
- Read: when rd_en is high, rsN_data/rsN_busy are registered on posedge (1-cycle latency). When rd_en is low, the outputs hold their previous value.
- Bypass: if wr_en and wr_idx == rsN_idx in the same cycle as rd_en, rsN_data takes wr_data. rsN_busy reflects the post-update busy bit: 0 unless alloc_idx == rsN_idx in the same cycle. Bypass is never applied to index 0 when ZERO_REG=1.
- Index 0 with ZERO_REG=1: reads return 0 with busy 0.
- Both ports may read the same index; both return identical values.
- busy_count: registered population count of the busy vector after the current cycle's updates. Range 0..NUM_REGS-1 when ZERO_REG=1.
- No X propagation: registers are fully reset, so reads before any write return 0.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W and NUM_REGS defaults.
  - IDX_W derivation.
  - Typedefs reg_idx_t (IDX_W bits) and reg_data_t (DATA_W bits).
- Sub-module busy_scoreboard holds:
  - the NUM_REGS-bit busy vector with alloc/retire priority logic;
  - the popcount for busy_count;
  - combinational busy lookups for two indices (pre-register).
- Top level holds the data array, the read registers and the bypass muxes.

Test Plan:
1. Reset then read: assert reset 3 cycles, release, rd_en=1, rs1_idx=5, rs2_idx=0 -> next cycle rs1_data=0, rs2_data=0, both busy=0, busy_count=0.
2. Write then read: wr_en=1, wr_idx=7, wr_data=32'hDEADBEEF; next cycle rd_en with rs1_idx=7 -> one cycle later rs1_data=32'hDEADBEEF.
3. Same-cycle bypass: registers[3]=32'h11. In one cycle wr_en with wr_idx=3, wr_data=32'h22, plus rd_en with rs1_idx=3, rs2_idx=3 -> rs1_data=rs2_data=32'h22, rs1_busy=0.
4. Scoreboard:
   - alloc_idx=9 -> following read of 9 shows busy=1 and busy_count=1.
   - Same cycle alloc_idx=9 and wr_idx=9 -> busy stays 1.
   - wr_idx=9 alone -> busy=0, busy_count=0.
5. Register 0: wr_en with wr_idx=0, wr_data=32'hFFFF, plus alloc_idx=0 -> read of 0 returns data 0, busy 0, busy_count 0.
6. Async reset mid-operation:
   - Allocate regs 1..4 and write 32'hA5 to reg 2.
   - Pulse reset between clock edges -> all outputs 0 immediately, busy_count 0.
   - Read of reg 2 after release returns 0.
